// File: rtl/mmio_io_pkg.sv
// Shared constants for the board I/O controller: register offsets,
// STATUS bit positions and the active-low hex-to-segment table.
package mmio_io_pkg;

    localparam logic [7:0] OFF_STATUS  = 8'h00;
    localparam logic [7:0] OFF_SWITCH  = 8'h04;
    localparam logic [7:0] OFF_DISPLAY = 8'h08;
    localparam logic [7:0] OFF_CTRL    = 8'h0C;

    localparam int ST_L = 0;
    localparam int ST_R = 1;

    // Index 0 is the rightmost entry; segment bit 0 is 'a'.
    localparam logic [15:0][6:0] SEG_TBL = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        return SEG_TBL[h];
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// one-cycle pulse when the debounced level rises.
module io_debounce
    import mmio_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          accept;

    // Counter only runs while the synced input disagrees with dout.
    assign accept = (s2 != dout) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            dout <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            rise <= accept & s2;
            if (s2 == dout || accept) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                dout <= s2;
            end
        end
    end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped board I/O: sticky button events, synchronised switches
// and a multiplexed seven-segment display with blanking and DPs.
module mmio_io_ctrl
    import mmio_io_pkg::*;
#(
    parameter int N_DIGITS        = 8,
    parameter int SW_WIDTH        = 16,
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [7:0]          addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    input  logic                btnl,
    input  logic                btnr,
    input  logic [SW_WIDTH-1:0] sw,
    output logic [N_DIGITS-1:0] an,
    output logic [6:0]          a2g,
    output logic                dp
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    logic [1:0]          pending;
    logic [1:0]          rise_v;
    logic [1:0]          btn_lvl;
    logic [SW_WIDTH-1:0] sw_s1;
    logic [SW_WIDTH-1:0] sw_s2;
    logic [31:0]         display;
    logic [7:0]          dp_en;
    logic [7:0]          blank;
    logic [DW-1:0]       div;
    logic [IW-1:0]       idx;
    logic [7:0]          word;
    logic                sel_status;
    logic                sel_switch;
    logic                sel_display;
    logic                sel_ctrl;
    logic [1:0]          clr;
    logic [N_DIGITS-1:0] an_nxt;
    logic [6:0]          seg_nxt;
    logic                dp_nxt;
    logic                unused_bits;

    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
        .clk   (clk),
        .reset (reset),
        .din   (btnl),
        .dout  (btn_lvl[ST_L]),
        .rise  (rise_v[ST_L])
    );

    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
        .clk   (clk),
        .reset (reset),
        .din   (btnr),
        .dout  (btn_lvl[ST_R]),
        .rise  (rise_v[ST_R])
    );

    assign unused_bits = ^{btn_lvl, addr[1:0]};

    assign word        = {addr[7:2], 2'b00};
    assign sel_status  = (word == OFF_STATUS);
    assign sel_switch  = (word == OFF_SWITCH);
    assign sel_display = (word == OFF_DISPLAY);
    assign sel_ctrl    = (word == OFF_CTRL);
    assign clr         = (we && sel_status) ? wdata[1:0] : 2'b00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            sw_s1   <= '0;
            sw_s2   <= '0;
            display <= '0;
            dp_en   <= '0;
            blank   <= '0;
        end else begin
            // A new event beats a simultaneous write-1-to-clear.
            pending <= (pending & ~clr) | rise_v;
            sw_s1   <= sw;
            sw_s2   <= sw_s1;
            if (we && sel_display) begin
                display <= wdata;
            end
            if (we && sel_ctrl) begin
                dp_en <= wdata[7:0];
                blank <= wdata[15:8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            sel_status:  rdata = {30'b0, pending};
            sel_switch:  rdata = 32'(sw_s2);
            sel_display: rdata = display;
            sel_ctrl:    rdata = {16'b0, blank, dp_en};
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
            idx <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_comb begin
        an_nxt  = '1;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IW'(k) && !blank[k]) begin
                an_nxt[k] = 1'b0;
                seg_nxt   = hex2seg(display[4*k +: 4]);
                dp_nxt    = ~dp_en[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= '1;
            a2g <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            a2g <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Bench for mmio_io_ctrl: directed steps plus random register traffic
// against a cycle-count reference model.
module tb_mmio_io_ctrl;

    localparam int ND  = 4;
    localparam int SD  = 4;
    localparam int DB  = 8;
    localparam int SWW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            we;
    logic [7:0]      addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic            btnl;
    logic            btnr;
    logic [SWW-1:0]  sw;
    logic [ND-1:0]   an;
    logic [6:0]      a2g;
    logic            dp;

    always #5 clk = ~clk;

    mmio_io_ctrl #(
        .N_DIGITS        (ND),
        .SW_WIDTH        (SWW),
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .btnl  (btnl),
        .btnr  (btnr),
        .sw    (sw),
        .an    (an),
        .a2g   (a2g),
        .dp    (dp)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0]     seg_ref [16];
    logic [31:0]    m_disp;
    logic [15:0]    m_ctrl;
    logic [1:0]     m_stat;
    int             cyc;
    int             set_l;
    int             set_r;
    logic [SWW-1:0] sw_hist [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] a);
        logic [31:0] v;
        v = '0;
        case (a & 8'hFC)
            8'h00: v = {30'b0, m_stat};
            8'h04: if (sw_hist.size() >= 2) v = 32'(sw_hist[sw_hist.size()-2]);
            8'h08: v = m_disp;
            8'h0C: v = {16'b0, m_ctrl};
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_disp = '0;
        m_ctrl = '0;
        m_stat = '0;
        cyc    = 0;
        set_l  = -1;
        set_r  = -1;
        sw_hist.delete();
    endtask

    // One clock: predict outputs from the pre-edge model, advance, compare.
    task automatic step();
        int         k;
        logic [3:0] ean;
        logic [6:0] ea;
        logic       edp;
        k = (cyc / SD) % ND;
        if (m_ctrl[8+k]) begin
            ean = 4'hF;
            ea  = 7'h7F;
            edp = 1'b1;
        end else begin
            ean = ~(4'b0001 << k);
            ea  = seg_ref[m_disp[4*k +: 4]];
            edp = ~m_ctrl[k];
        end
        @(posedge clk);
        sw_hist.push_back(sw);
        if (we) begin
            case (addr & 8'hFC)
                8'h00: m_stat = m_stat & ~wdata[1:0];
                8'h08: m_disp = wdata;
                8'h0C: m_ctrl = wdata[15:0];
                default: ;
            endcase
        end
        cyc++;
        if (cyc == set_l) m_stat[0] = 1'b1;
        if (cyc == set_r) m_stat[1] = 1'b1;
        #1;
        we = 1'b0;
        chk("an", 32'(an), 32'(ean));
        chk("a2g", 32'(a2g), 32'(ea));
        chk("dp", 32'(dp), 32'(edp));
    endtask

    task automatic rd(input logic [7:0] a);
        addr = a;
        #1;
        chk("rdata", rdata, m_read(a));
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        #1;
        chk("rd_old", rdata, m_read(a));
        step();
    endtask

    task automatic chk_rst_out();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_a2g", 32'(a2g), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
    endtask

    initial begin
        logic [7:0]  ra;
        int          r;
        seg_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        reset = 1'b1;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        btnl  = 1'b0;
        btnr  = 1'b0;
        sw    = '0;
        model_reset();
        repeat (20) @(posedge clk);
        #1;
        chk_rst_out();
        rd(8'h00);
        rd(8'h08);
        rd(8'h0C);
        reset = 1'b0;

        wr(8'h08, 32'h0000_3210);
        repeat (20) step();
        wr(8'h0C, 32'h0000_0201);
        repeat (20) step();
        rd(8'h0C);
        wr(8'h0C, 32'hFFFF_0000);
        rd(8'h0C);
        repeat (6) step();

        btnr = 1'b1;
        repeat (3) begin step(); rd(8'h00); end
        btnr = 1'b0;
        repeat (3) begin step(); rd(8'h00); end
        btnr = 1'b1;
        set_r = cyc + DB + 3;
        repeat (DB + 6) begin step(); rd(8'h00); end
        chk("status_r", rdata, 32'h2);
        btnr = 1'b0;
        repeat (DB + 6) begin step(); rd(8'h00); end

        btnl = 1'b1;
        set_l = cyc + DB + 3;
        repeat (DB + 5) begin step(); rd(8'h00); end
        btnl = 1'b0;
        repeat (DB + 5) begin step(); rd(8'h00); end
        chk("status_lr", rdata, 32'h3);
        wr(8'h00, 32'h1);
        rd(8'h00);
        chk("w1c", rdata, 32'h2);

        btnl = 1'b1;
        set_l = cyc + DB + 3;
        repeat (DB + 2) step();
        wr(8'h00, 32'h1);
        rd(8'h00);
        chk("set_wins", rdata, 32'h3);
        btnl = 1'b0;
        repeat (12) step();
        wr(8'h00, 32'h3);
        rd(8'h00);

        sw = 16'hA5A5;
        step();
        rd(8'h04);
        step();
        rd(8'h04);
        chk("switch", rdata, 32'h0000_A5A5);

        wr(8'h10, 32'hDEAD_BEEF);
        rd(8'h10);
        rd(8'h08);
        rd(8'h0C);

        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 5);
            sw = SWW'($urandom);
            case (r)
                0: begin we = 1'b1; addr = 8'h08; end
                1: begin we = 1'b1; addr = 8'h0C; end
                2: begin we = 1'b1; addr = 8'h10 | 8'($urandom_range(0, 3)); end
                3: begin we = 1'b1; addr = 8'h04; end
                4: begin we = 1'b1; addr = 8'h00; end
                default: we = 1'b0;
            endcase
            wdata = $urandom;
            if (we) begin
                #1;
                chk("rnd_old", rdata, m_read(addr));
            end
            step();
            ra = 8'($urandom);
            if (r == 5) ra = 8'($urandom_range(0, 3)) << 2;
            rd(ra);
        end

        reset = 1'b1;
        #1;
        chk_rst_out();
        model_reset();
        rd(8'h08);
        rd(8'h0C);
        rd(8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk_rst_out();
        reset = 1'b0;
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
